// File: rtl/pwm_shadow_gen_pkg.sv
// Shared definitions for the double-buffered PWM generator.
package pwm_shadow_gen_pkg;

  // Default width of counter, period and duty.
  localparam int DEF_WIDTH = 16;

  // Shortest period the generator will run; shorter requests are raised to this.
  localparam int MIN_PERIOD = 2;

  // Generator state: IDLE holds the output inactive, RUN sweeps the counter.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } pwm_state_t;

endpackage

// File: rtl/pwm_shadow_gen_cfg_shadow.sv
// Configuration shadow: accepts (period, duty) over valid/ready, clamps the
// period, and holds the pair until the generator applies it at a boundary.
module pwm_cfg_shadow
  import pwm_shadow_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  input  logic             apply,
  output logic             pending,
  output logic [WIDTH-1:0] shadow_period,
  output logic [WIDTH-1:0] shadow_duty
);

  logic xfer;

  // Raise too-short periods to the minimum the counter can wrap on.
  function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] p);
    return (p < WIDTH'(MIN_PERIOD)) ? WIDTH'(MIN_PERIOD) : p;
  endfunction

  assign xfer = cfg_valid & cfg_ready;

  // Pending flag and its registered inverse; capture and apply never coincide
  // because capture needs ready (no pending) and apply needs pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      cfg_ready <= 1'b1;
    end else if (xfer) begin
      pending   <= 1'b1;
      cfg_ready <= 1'b0;
    end else if (apply) begin
      pending   <= 1'b0;
      cfg_ready <= 1'b1;
    end
  end

  // Shadow data only changes on a transfer; it is meaningless until pending is set.
  always_ff @(posedge clk) begin
    if (xfer) begin
      shadow_period <= clamp_period(cfg_period);
      shadow_duty   <= cfg_duty;
    end
  end

endmodule

// File: rtl/pwm_shadow_gen.sv
// Double-buffered PWM generator: counter, active period/duty, compare and
// registered outputs. New settings take effect only at a period boundary.
module pwm_shadow_gen
  import pwm_shadow_gen_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEF_PERIOD  = 20000,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             pwm_out,
  output logic             period_start,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  pwm_state_t       state, state_nxt;
  logic [WIDTH-1:0] act_period, act_duty;
  logic [WIDTH-1:0] act_period_nxt, act_duty_nxt, cnt_nxt;
  logic             apply, pending, run_nxt, ps_nxt, pwm_nxt;
  logic [WIDTH-1:0] shadow_period, shadow_duty;

  // Map the logical on-phase to the physical output level.
  function automatic logic drive_level(input logic on_phase);
    return on_phase ~^ ACTIVE_HIGH;
  endfunction

  pwm_cfg_shadow #(.WIDTH(WIDTH)) u_cfg_shadow (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_period    (cfg_period),
    .cfg_duty      (cfg_duty),
    .apply         (apply),
    .pending       (pending),
    .shadow_period (shadow_period),
    .shadow_duty   (shadow_duty)
  );

  // Next-state, next counter and apply decision; the output compare uses the
  // next-state values so pwm_out, cnt and period_start line up in one cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    apply     = 1'b0;
    run_nxt   = 1'b0;
    ps_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        // A pending pair is applied right away so the first period uses it.
        apply = pending;
        if (enable) begin
          state_nxt = S_RUN;
          run_nxt   = 1'b1;
          ps_nxt    = 1'b1;
        end
      end
      S_RUN: begin
        if (!enable) begin
          // Abandon the current period; any pending pair stays pending.
          state_nxt = S_IDLE;
        end else begin
          run_nxt = 1'b1;
          if (cnt == act_period - ONE) begin
            ps_nxt = 1'b1;
            apply  = pending;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    act_period_nxt = apply ? shadow_period : act_period;
    act_duty_nxt   = apply ? shadow_duty   : act_duty;
    pwm_nxt        = run_nxt ? drive_level(cnt_nxt < act_duty_nxt) : drive_level(1'b0);
  end

  // State, counter, active settings and the registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      act_period   <= WIDTH'(DEF_PERIOD);
      act_duty     <= '0;
      pwm_out      <= drive_level(1'b0);
      period_start <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      act_period   <= act_period_nxt;
      act_duty     <= act_duty_nxt;
      pwm_out      <= pwm_nxt;
      period_start <= ps_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_shadow_gen.sv
// Directed bench for pwm_shadow_gen: a vector table for the basic waveform and
// enable toggle, plus hand-written sequences for updates, bounds and reset.
module tb_pwm_shadow_gen;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         cfg_valid;
  logic [W-1:0] cfg_period;
  logic [W-1:0] cfg_duty;
  logic         cfg_ready, pwm_out, period_start;
  logic [W-1:0] cnt;
  logic         cfg_ready_n, pwm_out_n, period_start_n;
  logic [W-1:0] cnt_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit en;
    int cnt;
    bit pwm;
    bit ps;
  } vec_t;

  vec_t tbl[22];

  always #5 clk = ~clk;

  pwm_shadow_gen #(.WIDTH(W), .DEF_PERIOD(20000), .ACTIVE_HIGH(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_duty     (cfg_duty),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .cnt          (cnt)
  );

  pwm_shadow_gen #(.WIDTH(W), .DEF_PERIOD(20000), .ACTIVE_HIGH(1'b0)) dut_inv (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready_n),
    .cfg_period   (cfg_period),
    .cfg_duty     (cfg_duty),
    .pwm_out      (pwm_out_n),
    .period_start (period_start_n),
    .cnt          (cnt_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare all visible outputs of both instances against one expected cycle.
  task automatic check_now(input string tag, input int c, input bit p, input bit ps, input bit r);
    chk({tag, " cnt"}, int'(cnt), c);
    chk({tag, " pwm_out"}, int'(pwm_out), int'(p));
    chk({tag, " period_start"}, int'(period_start), int'(ps));
    chk({tag, " cfg_ready"}, int'(cfg_ready), int'(r));
    chk({tag, " pwm_out(inverted)"}, int'(pwm_out_n), int'(!p));
  endtask

  // Check n cycles of a running waveform starting at the currently shown cnt=0.
  task automatic run_check(input string tag, input int per, input int duty, input int n);
    for (int k = 0; k < n; k++) begin
      check_now(tag, k % per, (k % per) < duty, (k % per) == 0, 1'b1);
      step();
    end
  endtask

  // From any running state: stop, load (p, d) while idle, restart at cnt=0.
  task automatic apply_cfg(input string tag, input int p, input int d);
    enable = 1'b0;
    step();
    check_now({tag, " idle"}, 0, 1'b0, 1'b0, 1'b1);
    cfg_valid  = 1'b1;
    cfg_period = W'(p);
    cfg_duty   = W'(d);
    step();
    cfg_valid = 1'b0;
    check_now({tag, " captured"}, 0, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    step();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_duty = '0;

    // Vector table: 10/3 waveform for two periods, an enable drop, a restart.
    for (int i = 0; i < 20; i++) begin
      tbl[i].en  = 1'b1;
      tbl[i].cnt = i % 10;
      tbl[i].pwm = (i % 10) < 3;
      tbl[i].ps  = (i % 10) == 0;
    end
    tbl[20] = '{en: 1'b0, cnt: 0, pwm: 1'b0, ps: 1'b0};
    tbl[21] = '{en: 1'b1, cnt: 0, pwm: 1'b1, ps: 1'b1};

    // Reset and default waveform (period 20000, duty 0).
    step(); step();
    check_now("reset", 0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    step();
    check_now("post-reset idle", 0, 1'b0, 1'b0, 1'b1);
    enable = 1'b1;
    step();
    run_check("default", 20000, 0, 20001);

    // Basic 10/3 loaded while idle, driven from the table.
    enable = 1'b0;
    step();
    check_now("basic idle", 0, 1'b0, 1'b0, 1'b1);
    cfg_valid = 1'b1; cfg_period = 16'd10; cfg_duty = 16'd3;
    step();
    cfg_valid = 1'b0;
    check_now("basic captured", 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) begin
      enable = tbl[i].en;
      step();
      check_now($sformatf("table[%0d]", i), tbl[i].cnt, tbl[i].pwm, tbl[i].ps, 1'b1);
    end

    // Live update at cnt=4: old period completes, 20/5 starts at next cnt=0.
    for (int k = 1; k <= 4; k++) begin
      step();
      check_now("live pre", k, k < 3, 1'b0, 1'b1);
    end
    cfg_valid = 1'b1; cfg_period = 16'd20; cfg_duty = 16'd5;
    step();
    cfg_valid = 1'b0;
    for (int k = 5; k <= 9; k++) begin
      check_now("live old tail", k, 1'b0, 1'b0, 1'b0);
      step();
    end
    run_check("live new", 20, 5, 40);

    // Bounds.
    apply_cfg("duty0", 10, 0);
    run_check("duty0", 10, 0, 20);
    apply_cfg("duty=period", 10, 10);
    run_check("duty=period", 10, 10, 20);
    apply_cfg("duty=ffff", 10, 16'hFFFF);
    run_check("duty=ffff", 10, 16'hFFFF, 20);
    apply_cfg("period0", 0, 1);
    run_check("period0", 2, 1, 6);
    apply_cfg("period1", 1, 1);
    run_check("period1", 2, 1, 6);

    // Enable drop at cnt=5, load 8/2 while idle, restart.
    apply_cfg("drop", 10, 3);
    run_check("drop run", 10, 3, 5);
    enable = 1'b0;
    step();
    check_now("drop idle", 0, 1'b0, 1'b0, 1'b1);
    cfg_valid = 1'b1; cfg_period = 16'd8; cfg_duty = 16'd2;
    step();
    cfg_valid = 1'b0;
    check_now("idle captured", 0, 1'b0, 1'b0, 1'b0);
    step();
    check_now("idle applied", 0, 1'b0, 1'b0, 1'b1);
    enable = 1'b1;
    step();
    run_check("8/2", 8, 2, 16);

    // Reset with a pending 30/7 mid-period discards it.
    apply_cfg("rst", 10, 3);
    run_check("rst run", 10, 3, 4);
    cfg_valid = 1'b1; cfg_period = 16'd30; cfg_duty = 16'd7;
    step();
    cfg_valid = 1'b0;
    check_now("rst pending", 5, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0; enable = 1'b0;
    step(); step();
    check_now("rst mid", 0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    step();
    check_now("rst released", 0, 1'b0, 1'b0, 1'b1);
    enable = 1'b1;
    step();
    run_check("rst default", 20000, 0, 20001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
